// File: rtl/mips_mem_responder.sv
// Word-addressed RAM target for the multicycle MIPS bus; reads complete READ_LAT and writes WRITE_LAT edges after sampling.
// Requests are held by the processor until the one-cycle memready pulse; inputs are ignored while busy.
module mips_mem_responder #(
   parameter int ADDR_BITS = 8,
   parameter int READ_LAT  = 2,
   parameter int WRITE_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          addr,
   input  logic                 memread,
   input  logic                 memwrite,
   input  logic [31:0]          writedata,
   output logic [31:0]          memdata,
   output logic                 memready,
   output logic                 busy,
   output logic                 err,
   input  logic                 ld_en,
   input  logic [ADDR_BITS-1:0] ld_addr,
   input  logic [31:0]          ld_data
);

   localparam int DEPTH   = 1 << ADDR_BITS;
   localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] WR_WAIT = 2'd2;
   localparam logic [1:0] RESP    = 2'd3;

   logic [1:0]           state;
   logic [CNT_W-1:0]     cnt;
   logic [ADDR_BITS-1:0] idx_q;
   logic [31:0]          wdata_q;
   logic                 fault_q;
   logic                 err_q;
   logic [31:0]          mem [DEPTH];

   logic                 req_fault;
   logic                 ram_we;
   logic [ADDR_BITS-1:0] ram_waddr;
   logic [31:0]          ram_wdata;

   assign req_fault = (addr[1:0] != 2'b00) || (addr[31:ADDR_BITS+2] != '0);
   assign memready  = (state == RESP);
   assign busy      = (state != IDLE);
   assign err       = memready & err_q;

   // Single write port shared by the bus commit and the backdoor; the two are mutually exclusive by state.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = idx_q;
      ram_wdata = wdata_q;
      if (state == WR_WAIT && cnt == '0 && !fault_q) begin
         ram_we = 1'b1;
      end else if (state == IDLE && ld_en && !memread && !memwrite) begin
         ram_we    = 1'b1;
         ram_waddr = ld_addr;
         ram_wdata = ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         fault_q <= 1'b0;
         err_q   <= 1'b0;
         memdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (memread || memwrite) begin
                  idx_q   <= addr[ADDR_BITS+1:2];
                  wdata_q <= writedata;
                  fault_q <= req_fault;
               end
               if (memread && memwrite) begin
                  state <= RESP;
                  err_q <= 1'b1;
               end else if (memread) begin
                  state <= RD_WAIT;
                  cnt   <= CNT_W'(READ_LAT - 1);
                  err_q <= req_fault;
               end else if (memwrite) begin
                  state <= WR_WAIT;
                  cnt   <= CNT_W'(WRITE_LAT - 1);
                  err_q <= req_fault;
               end
            end
            RD_WAIT: begin
               if (cnt == '0) begin
                  state   <= RESP;
                  memdata <= fault_q ? 32'h0 : mem[idx_q];
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            WR_WAIT: begin
               if (cnt == '0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               state <= IDLE;
               err_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: one instance with default latencies, one with WRITE_LAT=3 for the abort case.
module tb_mips_mem_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b0, memread = 1'b0, memwrite = 1'b0, ld_en = 1'b0;
   logic [31:0] addr = '0, writedata = '0, ld_data = '0, memdata;
   logic [7:0]  ld_addr = '0;
   logic        memready, busy, err;

   logic        b_reset = 1'b0, b_memread = 1'b0, b_memwrite = 1'b0, b_ld_en = 1'b0;
   logic [31:0] b_addr = '0, b_writedata = '0, b_ld_data = '0, b_memdata;
   logic [7:0]  b_ld_addr = '0;
   logic        b_memready, b_busy, b_err;

   int checks = 0;
   int failures = 0;

   mips_mem_responder #(.ADDR_BITS(8), .READ_LAT(2), .WRITE_LAT(1)) dut (
      .clk(clk), .reset(reset), .addr(addr), .memread(memread), .memwrite(memwrite),
      .writedata(writedata), .memdata(memdata), .memready(memready), .busy(busy), .err(err),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

   mips_mem_responder #(.ADDR_BITS(8), .READ_LAT(2), .WRITE_LAT(3)) dut_b (
      .clk(clk), .reset(b_reset), .addr(b_addr), .memread(b_memread), .memwrite(b_memwrite),
      .writedata(b_writedata), .memdata(b_memdata), .memready(b_memready), .busy(b_busy), .err(b_err),
      .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data));

   // Called 1ns after a rising edge with the DUT idle; returns 1ns after the following idle edge.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic e, output logic [31:0] d,
                         output int bcnt, output logic leak);
      memread = rd; memwrite = wr; addr = a; writedata = wd;
      lat = -1; e = 1'b0; d = '0; bcnt = 0; leak = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 20; k++) begin
         if (busy) bcnt++;
         if (memready) begin
            lat = k; e = err; d = memdata;
            break;
         end
         if (err) leak = 1'b1;
         if (k == 0) begin
            addr = 32'hFFFF_FFF3; writedata = 32'hBAD0_BAD0;
         end
         @(posedge clk); #1;
      end
      memread = 1'b0; memwrite = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic b_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic e, output logic [31:0] d);
      b_memread = rd; b_memwrite = wr; b_addr = a; b_writedata = wd;
      lat = -1; e = 1'b0; d = '0;
      @(posedge clk); #1;
      for (int k = 0; k < 20; k++) begin
         if (b_memready) begin
            lat = k; e = b_err; d = b_memdata;
            break;
         end
         @(posedge clk); #1;
      end
      b_memread = 1'b0; b_memwrite = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic ld(input logic [7:0] i, input logic [31:0] v);
      ld_en = 1'b1; ld_addr = i; ld_data = v;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic b_ld(input logic [7:0] i, input logic [31:0] v);
      b_ld_en = 1'b1; b_ld_addr = i; b_ld_data = v;
      @(posedge clk); #1;
      b_ld_en = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (memdata !== 32'h0) begin failures++; $display("FAIL rst_memdata got=%h exp=00000000", memdata); end
      checks++; if (memready !== 1'b0) begin failures++; $display("FAIL rst_memready got=%b exp=0", memready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
      reset = 1'b1; b_reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_backdoor_read;
      int lat, bcnt; logic e, leak; logic [31:0] d;
      ld(8'd3, 32'hDEAD_BEEF);
      access(1'b1, 1'b0, 32'h0000_000C, 32'h0, lat, e, d, bcnt, leak);
      checks++; if (lat !== 2) begin failures++; $display("FAIL bd_read_lat got=%0d exp=2", lat); end
      checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bd_read_data got=%h exp=deadbeef", d); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL bd_read_err got=%b exp=0", e); end
      checks++; if (bcnt !== 3) begin failures++; $display("FAIL bd_read_busy got=%0d exp=3", bcnt); end
      checks++; if (leak !== 1'b0) begin failures++; $display("FAIL bd_read_err_leak got=%b exp=0", leak); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bd_read_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_write_read;
      int lat, bcnt; logic e, leak; logic [31:0] d;
      access(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, lat, e, d, bcnt, leak);
      checks++; if (lat !== 1) begin failures++; $display("FAIL wr_lat got=%0d exp=1", lat); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", e); end
      checks++; if (bcnt !== 2) begin failures++; $display("FAIL wr_busy got=%0d exp=2", bcnt); end
      access(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, e, d, bcnt, leak);
      checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL wr_readback got=%h exp=12345678", d); end
   endtask

   task automatic test_illegal;
      int lat, bcnt; logic e, leak; logic [31:0] d;
      access(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, lat, e, d, bcnt, leak);
      checks++; if (lat !== 0) begin failures++; $display("FAIL ill_lat got=%0d exp=0", lat); end
      checks++; if (e !== 1'b1) begin failures++; $display("FAIL ill_err got=%b exp=1", e); end
      checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL ill_memdata got=%h exp=12345678", d); end
      access(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, e, d, bcnt, leak);
      checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL ill_reread got=%h exp=12345678", d); end
   endtask

   task automatic test_misaligned;
      int lat, bcnt; logic e, leak; logic [31:0] d;
      access(1'b1, 1'b0, 32'h0000_000E, 32'h0, lat, e, d, bcnt, leak);
      checks++; if (lat !== 2) begin failures++; $display("FAIL mis_lat got=%0d exp=2", lat); end
      checks++; if (e !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", e); end
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL mis_data got=%h exp=00000000", d); end
      checks++; if (leak !== 1'b0) begin failures++; $display("FAIL mis_err_leak got=%b exp=0", leak); end
   endtask

   task automatic test_out_of_range;
      int lat, bcnt; logic e, leak; logic [31:0] d;
      ld(8'd0, 32'h0000_0001);
      access(1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, lat, e, d, bcnt, leak);
      checks++; if (lat !== 1) begin failures++; $display("FAIL oor_lat got=%0d exp=1", lat); end
      checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", e); end
      access(1'b1, 1'b0, 32'h0000_0000, 32'h0, lat, e, d, bcnt, leak);
      checks++; if (d !== 32'h0000_0001) begin failures++; $display("FAIL oor_alias got=%h exp=00000001", d); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL oor_read_err got=%b exp=0", e); end
   endtask

   task automatic test_back_to_back;
      int lat, bcnt; logic e, leak; logic [31:0] d;
      access(1'b1, 1'b0, 32'h0000_000C, 32'h0, lat, e, d, bcnt, leak);
      checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL b2b_first got=%h exp=deadbeef", d); end
      access(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, e, d, bcnt, leak);
      checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL b2b_second got=%h exp=12345678", d); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (memdata !== 32'h1234_5678) begin failures++; $display("FAIL b2b_hold got=%h exp=12345678", memdata); end
   endtask

   task automatic test_reset_abort;
      int lat; logic e; logic [31:0] d;
      b_ld(8'd5, 32'hAAAA_AAAA);
      b_access(1'b1, 1'b0, 32'h0000_0014, 32'h0, lat, e, d);
      checks++; if (d !== 32'hAAAA_AAAA) begin failures++; $display("FAIL ab_preload got=%h exp=aaaaaaaa", d); end
      b_access(1'b0, 1'b1, 32'h0000_0018, 32'h6666_6666, lat, e, d);
      checks++; if (lat !== 3) begin failures++; $display("FAIL ab_wlat3 got=%0d exp=3", lat); end
      b_access(1'b1, 1'b0, 32'h0000_0018, 32'h0, lat, e, d);
      checks++; if (d !== 32'h6666_6666) begin failures++; $display("FAIL ab_wlat3_data got=%h exp=66666666", d); end
      b_memwrite = 1'b1; b_addr = 32'h0000_0014; b_writedata = 32'h5555_5555;
      @(posedge clk); #1;
      checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL ab_busy_pre got=%b exp=1", b_busy); end
      @(posedge clk); #1;
      b_reset = 1'b0;
      #1;
      checks++; if (b_memready !== 1'b0) begin failures++; $display("FAIL ab_memready got=%b exp=0", b_memready); end
      checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL ab_busy got=%b exp=0", b_busy); end
      checks++; if (b_err !== 1'b0) begin failures++; $display("FAIL ab_err got=%b exp=0", b_err); end
      checks++; if (b_memdata !== 32'h0) begin failures++; $display("FAIL ab_memdata got=%h exp=00000000", b_memdata); end
      b_memwrite = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      b_reset = 1'b1;
      @(posedge clk); #1;
      b_access(1'b1, 1'b0, 32'h0000_0014, 32'h0, lat, e, d);
      checks++; if (d !== 32'hAAAA_AAAA) begin failures++; $display("FAIL ab_no_commit got=%h exp=aaaaaaaa", d); end
   endtask

   initial begin
      test_reset;
      test_backdoor_read;
      test_write_read;
      test_illegal;
      test_misaligned;
      test_out_of_range;
      test_back_to_back;
      test_reset_abort;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
